syncram_tdp_be: RTL

//  Parametrised true-dual-port synchronous RAM with per-byte write enables, 1- or
//  2-cycle read latency, selectable read-during-write behaviour, address stall and

---
 rtl/syncram_tdp_be_if.sv | 38 +++
 rtl/syncram_tdp_be.sv | 102 ++++++++++
 2 files changed

// File: rtl/syncram_tdp_be_if.sv
// Port bundle for the true-dual-port byte-enable RAM: clock enable, both access
// ports and the registered read data / collision outputs.
interface syncram_tdp_be_if #(
  parameter int WIDTH     = 32,
  parameter int WIDTHAD   = 8,
  parameter int BYTE_SIZE = 8
);
  localparam int NBE = WIDTH / BYTE_SIZE;

  logic               clocken0;
  logic [WIDTHAD-1:0] address_a;
  logic [WIDTHAD-1:0] address_b;
  logic [WIDTH-1:0]   data_a;
  logic [WIDTH-1:0]   data_b;
  logic               wren_a;
  logic               wren_b;
  logic               rden_a;
  logic               rden_b;
  logic [NBE-1:0]     byteena_a;
  logic [NBE-1:0]     byteena_b;
  logic               addressstall_a;
  logic               addressstall_b;
  logic [WIDTH-1:0]   q_a;
  logic [WIDTH-1:0]   q_b;
  logic               collision;

  modport master (
    output clocken0, address_a, address_b, data_a, data_b, wren_a, wren_b,
           rden_a, rden_b, byteena_a, byteena_b, addressstall_a, addressstall_b,
    input  q_a, q_b, collision
  );

  modport slave (
    input  clocken0, address_a, address_b, data_a, data_b, wren_a, wren_b,
           rden_a, rden_b, byteena_a, byteena_b, addressstall_a, addressstall_b,
    output q_a, q_b, collision
  );
endinterface

// File: rtl/syncram_tdp_be.sv
// True-dual-port synchronous RAM with byte enables, 1- or 2-edge read latency,
// per-port address stall and a registered write-collision pulse; no backpressure.
module syncram_tdp_be #(
  parameter int    WIDTH      = 32,
  parameter int    WIDTHAD    = 8,
  parameter int    NUMWORDS   = 2**WIDTHAD,
  parameter int    BYTE_SIZE  = 8,
  parameter int    RD_LATENCY = 1,
  parameter string RDW_MODE   = "OLD_DATA"
) (
  input  logic            clock0,
  input  logic            aclr0,
  syncram_tdp_be_if.slave bus
);
  localparam int               NBE      = WIDTH / BYTE_SIZE;
  localparam logic [WIDTHAD:0] NW       = NUMWORDS[WIDTHAD:0];
  localparam bit               NEW_DATA = (RDW_MODE == "NEW_DATA");

  logic [WIDTH-1:0] mem [NUMWORDS];

  logic [WIDTHAD-1:0] last_a_q, last_a_d, last_b_q, last_b_d;
  logic [WIDTH-1:0]   stage1_a_q, stage1_a_d, stage1_b_q, stage1_b_d;
  logic [WIDTH-1:0]   stage2_a_q, stage2_a_d, stage2_b_q, stage2_b_d;
  logic               collision_q, collision_d;

  logic [WIDTHAD-1:0] eff_a, eff_b;
  logic               in_a, in_b, wr_a, wr_b, same_addr;
  logic [WIDTH-1:0]   rd_word_a, rd_word_b, merged_a, merged_b;

  always_comb begin
    eff_a     = bus.addressstall_a ? last_a_q : bus.address_a;
    eff_b     = bus.addressstall_b ? last_b_q : bus.address_b;
    in_a      = {1'b0, eff_a} < NW;
    in_b      = {1'b0, eff_b} < NW;
    wr_a      = bus.wren_a & in_a;
    wr_b      = bus.wren_b & in_b;
    same_addr = (eff_a == eff_b);
    rd_word_a = in_a ? mem[eff_a] : '0;
    rd_word_b = in_b ? mem[eff_b] : '0;

    // Same-port view of the word after this edge's write, for NEW_DATA reads
    merged_a = rd_word_a;
    merged_b = rd_word_b;
    for (int i = 0; i < NBE; i++) begin
      if (bus.byteena_a[i]) merged_a[i*BYTE_SIZE +: BYTE_SIZE] = bus.data_a[i*BYTE_SIZE +: BYTE_SIZE];
      if (bus.byteena_b[i]) merged_b[i*BYTE_SIZE +: BYTE_SIZE] = bus.data_b[i*BYTE_SIZE +: BYTE_SIZE];
    end
  end

  always_comb begin
    last_a_d    = last_a_q;
    last_b_d    = last_b_q;
    stage1_a_d  = stage1_a_q;
    stage1_b_d  = stage1_b_q;
    stage2_a_d  = stage2_a_q;
    stage2_b_d  = stage2_b_q;
    collision_d = 1'b0;
    if (bus.clocken0) begin
      last_a_d   = eff_a;
      last_b_d   = eff_b;
      stage2_a_d = stage1_a_q;
      stage2_b_d = stage1_b_q;
      if (bus.rden_a) stage1_a_d = (NEW_DATA && wr_a) ? merged_a : rd_word_a;
      if (bus.rden_b) stage1_b_d = (NEW_DATA && wr_b) ? merged_b : rd_word_b;
      collision_d = bus.wren_a & bus.wren_b & same_addr & (|(bus.byteena_a & bus.byteena_b));
    end
  end

  // The array itself is never cleared; reset only blocks writes on its edges
  always_ff @(posedge clock0 or posedge aclr0) begin
    if (aclr0) begin
      last_a_q    <= '0;
      last_b_q    <= '0;
      stage1_a_q  <= '0;
      stage1_b_q  <= '0;
      stage2_a_q  <= '0;
      stage2_b_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      last_a_q    <= last_a_d;
      last_b_q    <= last_b_d;
      stage1_a_q  <= stage1_a_d;
      stage1_b_q  <= stage1_b_d;
      stage2_a_q  <= stage2_a_d;
      stage2_b_q  <= stage2_b_d;
      collision_q <= collision_d;
      if (bus.clocken0) begin
        for (int i = 0; i < NBE; i++) begin
          // Port A owns any byte both ports write at the same address
          if (wr_b && bus.byteena_b[i] && !(wr_a && same_addr && bus.byteena_a[i]))
            mem[eff_b][i*BYTE_SIZE +: BYTE_SIZE] <= bus.data_b[i*BYTE_SIZE +: BYTE_SIZE];
          if (wr_a && bus.byteena_a[i])
            mem[eff_a][i*BYTE_SIZE +: BYTE_SIZE] <= bus.data_a[i*BYTE_SIZE +: BYTE_SIZE];
        end
      end
    end
  end

  assign bus.q_a       = (RD_LATENCY == 2) ? stage2_a_q : stage1_a_q;
  assign bus.q_b       = (RD_LATENCY == 2) ? stage2_b_q : stage1_b_q;
  assign bus.collision = collision_q;
endmodule
